// File: rtl/spi_flash_pkg.sv
// Shared types and opcodes for the SPI flash controller.
// SPI_FLASH_CTRL_DUMMY_EN adds a dummy byte after the address.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
`ifdef SPI_FLASH_CTRL_DUMMY_EN
    ST_DUMMY,
`endif
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_FAST_READ   = 8'h0B;
  localparam logic [7:0] OP_PAGE_PROG   = 8'h02;
  localparam logic [7:0] OP_READ_STATUS = 8'h05;
  localparam logic [7:0] OP_WRITE_EN    = 8'h06;

  function automatic logic [8:0] byte_total(
    input logic       ae,
    input logic [7:0] n
  );
    logic [8:0] b;
    b = 9'd1 + {1'b0, n};
    if (ae) b = b + 9'd3;
`ifdef SPI_FLASH_CTRL_DUMMY_EN
    if (ae) b = b + 9'd1;
`endif
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_ctrl_if.sv
// System-side request/response bundle of the SPI flash controller.
// master = register/DMA side, slave = controller.
interface spi_flash_ctrl_if;
  logic        start;
  logic [7:0]  opcode;
  logic [23:0] addr;
  logic        addr_en;
  logic [7:0]  len;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  modport master (
    output start, opcode, addr, addr_en, len, wr_data,
    input  wr_ready, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  start, opcode, addr, addr_en, len, wr_data,
    output wr_ready, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/spi_byte_engine.sv
// SCK divider and one-byte full-duplex mode-0 shifter.
// byte_done marks the last SCK fall; load there chains the next byte.
module spi_byte_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       poci,
  output logic       busy,
  output logic       byte_done,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       copi
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_sh;
  logic [6:0]    rx_sh;
  logic          tick;
  logic          sample;

  assign tick      = busy && div_cnt == DW'(CLK_DIV - 1);
  assign byte_done = tick && sck && bit_cnt == 3'd7;
  // POCI is taken at the end of the first SCK-high cycle
  assign sample    = busy && sck && div_cnt == '0;
  assign rx_valid  = sample && bit_cnt == 3'd7;
  assign rx_byte   = {rx_sh, poci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      sck     <= 1'b0;
      copi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      if (sample) rx_sh <= rx_byte[6:0];
      if (!busy) begin
        if (load) begin
          busy    <= 1'b1;
          div_cnt <= '0;
          bit_cnt <= '0;
          tx_sh   <= tx_byte[6:0];
          copi    <= tx_byte[7];
        end
      end else if (tick) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
            if (load) begin
              tx_sh <= tx_byte[6:0];
              copi  <= tx_byte[7];
            end else begin
              busy <= 1'b0;
              copi <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[5:0], 1'b0};
            copi    <= tx_sh[6];
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end
endmodule

// File: rtl/spi_flash_ctrl.sv
// SPI flash transaction sequencer: CMD, ADDR, DUMMY, DATA, HOLD, GAP.
// SPI_FLASH_CTRL_DUMMY_EN inserts a dummy byte when addr_en is set.
module spi_flash_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_flash_ctrl_if.slave bus,
  output logic            SCK,
  output logic            CS_N,
  output logic            COPI,
  input  logic            POCI
);
  import spi_flash_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state;
  state_t        nxt;
  logic [8:0]    cnt;
  logic [8:0]    rem;
  logic [8:0]    tail;
  logic [23:0]   addr_sh;
  logic [7:0]    len_q;
  logic [DW-1:0] tmr;
  logic          busy_q;
  logic          done_q;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    tx_byte;
  logic          go;
  logic          load;
  logic          eng_busy;
  logic          eng_done;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  assign go  = state == ST_IDLE && bus.start && !eng_busy;
  assign rem = cnt - 9'd1;

`ifdef SPI_FLASH_CTRL_DUMMY_EN
  logic ae_q;
  assign tail = {1'b0, len_q} + {8'd0, ae_q};
`else
  assign tail = {1'b0, len_q};
`endif

  // phase of the following byte follows from how many remain
  always_comb begin
    nxt = ST_DATA;
    if (rem == 9'd0)
      nxt = ST_HOLD;
    else if (rem > tail)
      nxt = ST_ADDR;
`ifdef SPI_FLASH_CTRL_DUMMY_EN
    else if (rem > {1'b0, len_q})
      nxt = ST_DUMMY;
`endif
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state == ST_IDLE)
      tx_byte = bus.opcode;
    else if (nxt == ST_ADDR)
      tx_byte = addr_sh[23:16];
    else if (nxt == ST_DATA)
      tx_byte = bus.wr_data;
  end

  assign load = go || (eng_done && nxt != ST_HOLD);

  assign bus.wr_ready = eng_done && nxt == ST_DATA;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .tx_byte   (tx_byte),
    .poci      (POCI),
    .busy      (eng_busy),
    .byte_done (eng_done),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .sck       (SCK),
    .copi      (COPI)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_sh    <= '0;
      len_q      <= '0;
      tmr        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      CS_N       <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef SPI_FLASH_CTRL_DUMMY_EN
      ae_q       <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= rx_valid && state == ST_DATA;
      if (rx_valid && state == ST_DATA) rd_data_q <= rx_byte;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            state   <= ST_CMD;
            busy_q  <= 1'b1;
            CS_N    <= 1'b0;
            addr_sh <= bus.addr;
            len_q   <= bus.len;
            cnt     <= byte_total(bus.addr_en, bus.len);
`ifdef SPI_FLASH_CTRL_DUMMY_EN
            ae_q    <= bus.addr_en;
`endif
          end
        end
        ST_HOLD: begin
          if (tmr == DW'(CLK_DIV - 1)) begin
            state  <= ST_GAP;
            tmr    <= '0;
            CS_N   <= 1'b1;
            done_q <= 1'b1;
          end else begin
            tmr <= tmr + DW'(1);
          end
        end
        ST_GAP: begin
          if (tmr == DW'(CLK_DIV - 1)) begin
            state  <= ST_IDLE;
            tmr    <= '0;
            busy_q <= 1'b0;
          end else begin
            tmr <= tmr + DW'(1);
          end
        end
        default: begin
          if (eng_done) begin
            state <= nxt;
            cnt   <= rem;
            tmr   <= '0;
            if (nxt == ST_ADDR) addr_sh <= {addr_sh[15:0], 8'h00};
          end
        end
      endcase
    end
  end
endmodule
